// File: rtl/wb_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// wb_seq_ctrl_pkg
// Shared definitions for the writeback sequencer:
//   - state_t        : sequencer state encoding
//   - RW_DEF         : default register-index width
//   - RA_IDX_DEF     : default link register written by calls
//   - TIMEOUT_DEF    : default number of wait cycles allowed for mem_rdy
// -----------------------------------------------------------------------------
package wb_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_WRITE    = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

  localparam int RW_DEF      = 4;
  localparam int RA_IDX_DEF  = 15;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/wb_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wb_seq_ctrl
// Writeback sequencer between execute, data memory and the register file.
// Accepts one instruction at a time, runs the memory handshake for loads and
// stores, enforces a wait timeout and drives the writeback-mux selects plus a
// one-cycle register-file write strobe.
//
// Handshakes (valid/ready):
//   ex_valid/ex_ready : a transfer happens on a rising edge where both are 1;
//                       ex_valid may be raised regardless of ex_ready.
//   mem_req/mem_rdy   : mem_req stays high until an edge where mem_rdy is 1;
//                       that edge completes the request (mem_rdata sampled
//                       for loads). mem_rdy while mem_req is low is ignored.
//
// Ports:
//   clk, reset            clock (rising edge), async active-high reset
//   ex_valid/ex_ready     instruction offer / accept
//   ex_is_ld/st/call      instruction type (priority ld > st > call > ALU)
//   ex_rd                 destination register
//   mem_req/mem_we        memory request / store qualifier
//   mem_rdy/mem_rdata     memory completion / load data
//   ld_result             captured load data
//   wb_is_ld/wb_is_call   writeback-mux selects
//   rf_we/rf_waddr        register-file write strobe / index
//   mem_err               sticky timeout flag (cleared only by reset)
// The FSM state is visible on the internal signal 'state'.
// -----------------------------------------------------------------------------
module wb_seq_ctrl
  import wb_seq_ctrl_pkg::*;
#(
  parameter int RW      = RW_DEF,
  parameter int RA_IDX  = RA_IDX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_valid,
  output logic          ex_ready,
  input  logic          ex_is_ld,
  input  logic          ex_is_st,
  input  logic          ex_is_call,
  input  logic [RW-1:0] ex_rd,
  output logic          mem_req,
  output logic          mem_we,
  input  logic          mem_rdy,
  input  logic [31:0]   mem_rdata,
  output logic [31:0]   ld_result,
  output logic          wb_is_ld,
  output logic          wb_is_call,
  output logic          rf_we,
  output logic [RW-1:0] rf_waddr,
  output logic          mem_err
);

  // Counter only has to reach TIMEOUT-1; ERR is entered before it could wrap.
  localparam int CW = $clog2(TIMEOUT);

  state_t          state;
  state_t          state_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_n;

  logic            lat_ld;
  logic            lat_st;
  logic            lat_call;
  logic [RW-1:0]   lat_idx;
  logic [31:0]     ld_data;

  logic            accept;
  logic            cnt_last;
  logic            dec_st;
  logic            dec_call;

  assign accept   = (state == ST_IDLE) && ex_valid;
  assign cnt_last = (cnt == CW'(TIMEOUT - 1));

  // Type priority: a load masks store and call; a store masks call.
  assign dec_st   = ex_is_st && !ex_is_ld;
  assign dec_call = ex_is_call && !ex_is_ld && !ex_is_st;

  // ---------------------------------------------------------------------------
  // State register and timeout counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      ST_IDLE: begin
        if (ex_valid) begin
          if (ex_is_ld || ex_is_st) begin
            state_n = ST_MEM_WAIT;
            cnt_n   = '0;
          end else begin
            state_n = ST_WRITE;
          end
        end
      end
      ST_MEM_WAIT: begin
        // A completion in the final allowed cycle still beats the timeout.
        if (mem_rdy) begin
          state_n = lat_ld ? ST_WRITE : ST_IDLE;
        end else if (cnt_last) begin
          state_n = ST_ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WRITE: state_n = ST_IDLE;
      ST_ERR:   state_n = ST_ERR;
      default:  state_n = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Instruction latches and load-data capture
  // The writeback selects change only on accept, so they are stable from the
  // start of WRITE until the next instruction is taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_ld   <= 1'b0;
      lat_st   <= 1'b0;
      lat_call <= 1'b0;
      lat_idx  <= '0;
      ld_data  <= '0;
    end else begin
      if (accept) begin
        lat_ld   <= ex_is_ld;
        lat_st   <= dec_st;
        lat_call <= dec_call;
        lat_idx  <= dec_call ? RW'(RA_IDX) : ex_rd;
      end
      if ((state == ST_MEM_WAIT) && mem_rdy && lat_ld) begin
        ld_data <= mem_rdata;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state or taken straight from registers
  // ---------------------------------------------------------------------------
  assign ex_ready   = (state == ST_IDLE);
  assign mem_req    = (state == ST_MEM_WAIT);
  assign mem_we     = (state == ST_MEM_WAIT) && lat_st;
  assign rf_we      = (state == ST_WRITE) && (lat_idx != '0);
  assign rf_waddr   = lat_idx;
  assign wb_is_ld   = lat_ld;
  assign wb_is_call = lat_call;
  assign ld_result  = ld_data;
  assign mem_err    = (state == ST_ERR);

endmodule
